ddr_frame_reader: RTL and testbench

- Read-side client of the DDR2 manager; the counterpart of the fractal writer path that fills DDR2.
- On `start`, fetches one frame (FRAME_WORDS words from BASE_ADDR) as fixed-length read bursts through the memory manager's read-command/read-data port.
- Buffers returned data in a small FIFO and presents it to a downstream consumer (display/readback) on a valid/ready stream.
- Lives in the 75 MHz fractal/user clock domain alongside ddr_mgr_main.

---
 rtl/ddr_frame_reader_pkg.sv | 16 +
 rtl/ddr_frame_reader_if.sv | 31 +++
 rtl/ddr_rd_fifo.sv | 64 ++++++
 rtl/ddr_frame_reader.sv | 120 ++++++++++++
 tb/tb_ddr_frame_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_frame_reader_pkg.sv
// Shared definitions for the DDR2 frame read path: default bus widths
// shared with the manager's read port and the reader FSM state encodings.
package ddr_frame_reader_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 32;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/ddr_frame_reader_if.sv
// Frame reader bus: read-command/read-data port towards the DDR2 manager
// plus the valid/ready output stream. master = reader, slave = environment.
interface ddr_frame_reader_if
    import ddr_frame_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output rd_req, rd_addr,
        input  rd_ack, rd_data_valid, rd_data,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_ack, rd_data_valid, rd_data,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/ddr_rd_fifo.sv
// Output FIFO with registered head. Ports: push/push_data in, pop in,
// head_valid/head_data out, count of resident entries, drop on push-at-full.
module ddr_rd_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          head_valid,
    output logic [DATA_W-1:0]             head_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          drop
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_n;
    logic              pop_ok;
    logic              push_ok;
    logic [CW-1:0]     rest;
    logic [CW-1:0]     count_n;

    assign pop_ok   = pop && (count != '0);
    // A pop frees the slot in the same cycle, so push at full is legal then.
    assign push_ok  = push && ((count != CW'(FIFO_DEPTH)) || pop_ok);
    assign drop     = push && !push_ok;
    assign rest     = count - CW'(pop_ok);
    assign count_n  = rest + CW'(push_ok);
    assign rd_ptr_n = rd_ptr + PW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push_ok);
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            // Next head is either the incoming beat (FIFO otherwise empty)
            // or an entry already sitting in storage.
            if (push_ok && (rest == '0)) begin
                head_data <= push_data;
            end else if (rest != '0) begin
                head_data <= mem[rd_ptr_n];
            end
        end
    end
endmodule

// File: rtl/ddr_frame_reader.sv
// Fetches one frame from DDR2 as fixed-length read bursts, credit-limited
// by the output FIFO. Ports: clk/rst, start/busy/done/overflow, bus (master).
module ddr_frame_reader
    import ddr_frame_reader_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          BURST_LEN   = 4,
    parameter int          FRAME_WORDS = 153600,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    ddr_frame_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int UW = CW + 1;
    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     remaining;
    logic [CW-1:0]     pending;
    logic [CW-1:0]     fifo_count;
    logic              fifo_drop;
    logic              ack;
    logic              ret;
    logic [UW-1:0]     used;
    logic              credit_ok;

    assign ack = (state == ST_REQ) && bus.rd_ack;
    // Unsolicited beats never drive pending below zero.
    assign ret = bus.rd_data_valid && (pending != '0);

    // Words already resident plus words still in flight must leave room
    // for a whole burst before the next command goes out.
    assign used      = UW'(fifo_count) + UW'(pending);
    assign credit_ok = (used + UW'(BURST_LEN)) <= UW'(FIFO_DEPTH);

    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);
    assign bus.rd_req  = (state == ST_REQ);
    assign bus.rd_addr = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= BASE;
            remaining <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= BASE;
                        remaining <= RW'(FRAME_WORDS);
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (remaining == '0) begin
                        state <= ST_DRAIN;
                    end else if (credit_ok) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.rd_ack) begin
                        addr      <= addr + ADDR_W'(BURST_LEN);
                        remaining <= remaining - RW'(BURST_LEN);
                        state     <= ST_CHECK;
                    end
                end
                ST_DRAIN: begin
                    if (pending == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending + (ack ? CW'(BURST_LEN) : '0) - CW'(ret);
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    ddr_rd_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.rd_data_valid),
        .push_data  (bus.rd_data),
        .pop        (bus.out_valid && bus.out_ready),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_data),
        .count      (fifo_count),
        .drop       (fifo_drop)
    );
endmodule

// File: tb/tb_ddr_frame_reader.sv
// Bench for ddr_frame_reader: randomized memory responder and consumer,
// checked against a frame-level model of the expected output stream.
module tb_ddr_frame_reader;
    localparam int          ADDR_W      = 25;
    localparam int          DATA_W      = 32;
    localparam int          BURST_LEN   = 4;
    localparam int          FRAME_WORDS = 32;
    localparam int unsigned BASE_ADDR   = 32'h1FF_FFF0;
    localparam int          FIFO_DEPTH  = 16;
    localparam int          LAT         = 5;
    localparam int          NCMD        = FRAME_WORDS / BURST_LEN;

    typedef struct {
        int          due;
        logic [31:0] data;
    } beat_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic overflow;

    ddr_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr_frame_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BASE_ADDR   (BASE_ADDR),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Shared state: main writes the knobs, responder owns the model.
    logic        start_req = 1'b0;
    int          budget    = 0;
    bit          rand_rdy  = 1'b0;
    bit          stall_nxt = 1'b0;
    int          inject_n  = 0;

    logic [31:0] exp_q[$];
    beat_t       resp_q[$];
    int          occ;
    bit          exp_ovf;
    bit          model_busy;
    logic [ADDR_W-1:0] exp_cmd;
    int          frame_ret;
    int          frame_cmd;
    int          done_cnt;
    int          cyc;

    // Memory responder, consumer and monitor, all at the negative edge.
    initial begin
        int          ack_wait;
        int          last_due;
        bit          hold_chk;
        logic [ADDR_W-1:0] hold_addr;
        bit          head_chk;
        logic [31:0] head_prev;
        bit          push_now;
        bit          is_frame;
        bit          pop_now;
        int          d;
        start             = 1'b0;
        bus.rd_ack        = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        bus.out_ready     = 1'b0;
        occ = 0; exp_ovf = 0; model_busy = 0; exp_cmd = '0;
        frame_ret = 0; frame_cmd = 0; done_cnt = 0; cyc = 0;
        ack_wait = 1; last_due = 0; hold_chk = 0; head_chk = 0;
        hold_addr = '0; head_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                resp_q.delete();
                occ = 0; exp_ovf = 0; model_busy = 0;
                ack_wait = 1; hold_chk = 0; head_chk = 0;
                start = 1'b0;
                bus.rd_ack = 1'b0;
                bus.rd_data_valid = 1'b0;
                bus.out_ready = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    model_busy = 0;
                    chk("done_beats", 64'(frame_ret), 64'(FRAME_WORDS));
                    chk("done_cmds", 64'(frame_cmd), 64'(NCMD));
                end
                if (hold_chk) begin
                    chk("req_hold", 64'(bus.rd_req), 64'd1);
                    chk("addr_hold", 64'(bus.rd_addr), 64'(hold_addr));
                end
                if (head_chk) begin
                    chk("head_hold", {31'd0, bus.out_valid, bus.out_data},
                        {31'd0, 1'b1, head_prev});
                end

                start = 1'b0;
                if (start_req) begin
                    start = 1'b1;
                    start_req = 1'b0;
                    if (!model_busy) begin
                        model_busy = 1;
                        exp_cmd = ADDR_W'(BASE_ADDR);
                        frame_ret = 0;
                        frame_cmd = 0;
                        for (int i = 0; i < FRAME_WORDS; i++)
                            exp_q.push_back(mem_word(ADDR_W'(BASE_ADDR + i)));
                    end
                end

                hold_chk = 0;
                bus.rd_ack = 1'b0;
                if (bus.rd_req) begin
                    if (ack_wait > 0) begin
                        ack_wait--;
                        hold_chk = 1;
                        hold_addr = bus.rd_addr;
                    end else begin
                        bus.rd_ack = 1'b1;
                        frame_cmd++;
                        chk("cmd_addr", 64'(bus.rd_addr), 64'(exp_cmd));
                        chk("credit", 64'(occ + resp_q.size() + BURST_LEN
                                          <= FIFO_DEPTH), 64'd1);
                        exp_cmd = exp_cmd + ADDR_W'(BURST_LEN);
                        d = cyc + LAT;
                        if (d <= last_due) d = last_due + 1;
                        for (int k = 0; k < BURST_LEN; k++) begin
                            beat_t b;
                            b.due  = d + k;
                            b.data = mem_word(bus.rd_addr + ADDR_W'(k));
                            resp_q.push_back(b);
                        end
                        last_due = d + BURST_LEN - 1;
                        ack_wait = stall_nxt ? 10 : int'($urandom_range(0, 2));
                        stall_nxt = 0;
                    end
                end

                bus.rd_data_valid = 1'b0;
                push_now = 0;
                is_frame = 0;
                if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data = resp_q[0].data;
                    void'(resp_q.pop_front());
                    frame_ret++;
                    push_now = 1;
                    is_frame = 1;
                end else if (inject_n > 0) begin
                    bus.rd_data_valid = 1'b1;
                    bus.rd_data = $urandom;
                    inject_n--;
                    push_now = 1;
                end

                bus.out_ready = (budget > 0) &&
                                (!rand_rdy || $urandom_range(0, 3) != 0);
                pop_now = bus.out_valid && bus.out_ready;
                head_chk = bus.out_valid && !bus.out_ready;
                head_prev = bus.out_data;
                if (pop_now) begin
                    budget--;
                    occ--;
                    chk("pop_known", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end
                if (push_now) begin
                    if (occ < FIFO_DEPTH) begin
                        occ++;
                        if (!is_frame) exp_q.push_back(bus.rd_data);
                    end else begin
                        exp_ovf = 1;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int lim);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic go();
        @(posedge clk);
        #2;
        start_req = 1'b1;
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        step(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_req", 64'(bus.rd_req), 64'd0);
        chk("rst_addr", 64'(bus.rd_addr), 64'(ADDR_W'(BASE_ADDR)));
        chk("rst_oval", 64'(bus.out_valid), 64'd0);
        chk("rst_odat", 64'(bus.out_data), 64'd0);
        rst = 1'b0;
        step(2);

        // Plain frame with an always-ready consumer; addresses wrap.
        budget = 100000;
        rand_rdy = 0;
        go();
        step(3);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done(500);
        chk("t1_busy_after", 64'(busy), 64'd0);
        wait_drain(200);
        chk("t1_ovf", 64'(overflow), 64'd0);

        // Consumer stalled: fetch must stop at FIFO capacity.
        budget = 0;
        go();
        step(150);
        chk("bp_cmds", 64'(frame_cmd), 64'(FIFO_DEPTH / BURST_LEN));
        chk("bp_req", 64'(bus.rd_req), 64'd0);
        chk("bp_ovf", 64'(overflow), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        budget = 100000;
        rand_rdy = 1;
        wait_done(1000);
        wait_drain(500);

        // Long ack stall, plus a start while busy that must be ignored.
        stall_nxt = 1;
        d0 = done_cnt;
        go();
        step(20);
        start_req = 1'b1;
        wait_done(1000);
        step(20);
        chk("single_done", 64'(done_cnt - d0), 64'd1);
        wait_drain(500);

        // Restart with 3 words left resident in the FIFO.
        rand_rdy = 0;
        budget = FRAME_WORDS - 3;
        go();
        wait_done(1000);
        step(10);
        chk("left_valid", 64'(bus.out_valid), 64'd1);
        chk("left_occ", 64'(occ), 64'd3);
        go();
        step(80);
        chk("left_cmds", 64'(frame_cmd), 64'd3);
        chk("left_req", 64'(bus.rd_req), 64'd0);
        budget = 100000;
        rand_rdy = 1;
        wait_done(1000);
        wait_drain(500);
        chk("left_ovf", 64'(overflow), 64'd0);

        // Unsolicited beats into a full FIFO.
        budget = 0;
        step(5);
        inject_n = FIFO_DEPTH + 1;
        step(30);
        chk("ovf_model", 64'(exp_ovf), 64'd1);
        chk("ovf_set", 64'(overflow), 64'd1);
        step(10);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_full", 64'(bus.out_valid), 64'd1);
        go();
        step(6);
        chk("full_busy", 64'(busy), 64'd1);
        chk("full_req", 64'(bus.rd_req), 64'd0);

        // Reset mid-frame takes effect without a clock edge.
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_oval", 64'(bus.out_valid), 64'd0);
        chk("arst_odat", 64'(bus.out_data), 64'd0);
        chk("arst_req", 64'(bus.rd_req), 64'd0);
        chk("arst_addr", 64'(bus.rd_addr), 64'(ADDR_W'(BASE_ADDR)));
        step(2);
        rst = 1'b0;
        step(2);

        // Recovery frame.
        budget = 100000;
        rand_rdy = 1;
        go();
        wait_done(1000);
        wait_drain(500);
        chk("end_ovf", 64'(overflow), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
